// File: rtl/apb_master_pkg.sv
// ---------------------------------------------------------------------------
// apb_master_pkg
// Shared types for the command-driven APB requester.
//   - state_e   : requester FSM states
//   - apb_cmd_t : one buffered command {write, addr, wdata}
//   - apb_rsp_t : one returned result  {rdata, error, timeout}
// Bus widths come from the shared DATA_WIDTH / ADDR_WIDTH defines. Defaults
// are provided here so the package also compiles standalone.
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package apb_master_pkg;

  localparam int APB_DW = `DATA_WIDTH;
  localparam int APB_AW = `ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DW-1:0] rdata;
    logic              error;
    logic              timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// ---------------------------------------------------------------------------
// apb_cmd_fifo
// Synchronous command buffer holding apb_cmd_t entries.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   push, push_data      : write an entry (ignored when full)
//   pop, pop_data        : pop_data shows the head entry; pop advances it
//   full, empty          : occupancy flags
// Pointers carry one extra wrap bit so equal indices can be told apart as
// either full (wrap bits differ) or empty (wrap bits equal).
// ---------------------------------------------------------------------------
module apb_cmd_fifo
  import apb_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  apb_cmd_t push_data,
  input  logic     pop,
  output apb_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_cmd_t      mem [DEPTH];
  logic [IW:0]   wr_ptr;
  logic [IW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[IW] != rd_ptr[IW]) &&
                    (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
// Turns valid/ready commands into two-phase APB transfers (with wait states
// and an optional PREADY timeout) and returns each result on a valid/ready
// response port. One transfer in flight at a time.
// Ports:
//   PCLK, PRESET                       : clock, async active-high reset
//   cmd_valid/ready/write/addr/wdata   : command input (buffered in a FIFO)
//   rsp_valid/ready/rdata/error/timeout: response output
//   PSELx, PENABLE, PWRITE, PADDR,
//   PWDATA, PRDATA, PREADY, PSLVERR    : APB requester side
// ---------------------------------------------------------------------------
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES) : '0;

  state_e           state;
  state_e           next_state;
  apb_cmd_t         push_cmd;
  apb_cmd_t         head_cmd;
  apb_rsp_t         rsp_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             timeout_hit;
  logic [CNT_W-1:0] wait_cnt;

  assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  apb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (PCLK),
    .rst       (PRESET),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The last waiting ACCESS cycle before the count would reach the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ACCESS) &&
                       !PREADY && (wait_cnt == CNT_LAST);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (!fifo_empty) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) next_state = RESP;
      RESP:    if (rsp_ready) next_state = fifo_empty ? IDLE : SETUP;
      default: next_state = IDLE;
    endcase
  end

  // A pop happens exactly when a new SETUP is entered from IDLE or RESP.
  always_comb begin
    PSELx     = (state == SETUP) || (state == ACCESS);
    PENABLE   = (state == ACCESS);
    rsp_valid = (state == RESP);
    cmd_ready = !fifo_full;
    fifo_pop  = (next_state == SETUP) && ((state == IDLE) || (state == RESP));
  end

  // Address/control/data are loaded at the pop edge and then held.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (fifo_pop) begin
      PWRITE <= head_cmd.write;
      PADDR  <= head_cmd.addr;
      PWDATA <= head_cmd.wdata;
    end
  end

  // Wait counter clears on entry to SETUP and saturates rather than wraps.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (next_state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Result is only written when leaving ACCESS, so it is stable in RESP.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_reg <= '0;
    end else if ((state == ACCESS) && PREADY) begin
      rsp_reg.rdata   <= (PWRITE || PSLVERR) ? '0 : PRDATA;
      rsp_reg.error   <= PSLVERR;
      rsp_reg.timeout <= 1'b0;
    end else if (timeout_hit) begin
      rsp_reg.rdata   <= '0;
      rsp_reg.error   <= 1'b1;
      rsp_reg.timeout <= 1'b1;
    end
  end

  assign rsp_rdata   = rsp_reg.rdata;
  assign rsp_error   = rsp_reg.error;
  assign rsp_timeout = rsp_reg.timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
// Directed bench for apb_cmd_master with hand-computed expectations. The DUT
// is built with an 8-cycle PREADY timeout; the APB completer is modelled by
// bench-driven PREADY/PSLVERR/PRDATA.
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_apb_cmd_master;

  localparam int DW = `DATA_WIDTH;
  localparam int AW = `ADDR_WIDTH;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  logic [DW-1:0] prdata_val;
  logic          use_addr_model;

  int checks = 0;
  int errors = 0;

  // In the FIFO test the completer returns a value derived from PADDR so
  // ordering of responses can be checked.
  assign PRDATA = use_addr_model ? (DW'(PADDR) ^ DW'(32'h3C)) : prdata_val;

  apb_cmd_master #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .rsp_timeout (rsp_timeout),
    .PSELx       (PSELx),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic waitCycle();
    @(posedge PCLK);
    #1;
  endtask

  // Offers one command for exactly one edge; the FIFO must be able to take it.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    checkOutput("cmd_ready_before_push", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    waitCycle();
    cmd_valid = 1'b0;
  endtask

  logic [DW-1:0] exp_rdata [6];
  int            rsp_idx;
  int            cnt;
  logic          take_cmd;
  logic          accepted;
  logic          any_bad;

  initial begin
    PRESET         = 1'b1;
    cmd_valid      = 1'b0;
    cmd_write      = 1'b0;
    cmd_addr       = '0;
    cmd_wdata      = '0;
    rsp_ready      = 1'b0;
    PREADY         = 1'b0;
    PSLVERR        = 1'b0;
    prdata_val     = '0;
    use_addr_model = 1'b0;
    #1;
    checkOutput("rst_psel", PSELx, 0);
    checkOutput("rst_penable", PENABLE, 0);
    checkOutput("rst_pwrite", PWRITE, 0);
    checkOutput("rst_paddr", PADDR, 0);
    checkOutput("rst_pwdata", PWDATA, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_error", rsp_error, 0);
    checkOutput("rst_rsp_timeout", rsp_timeout, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    waitCycle();
    waitCycle();
    PRESET = 1'b0;
    waitCycle();

    // Zero-wait write to 0x04 with data 0xA5
    PREADY     = 1'b1;
    prdata_val = DW'(32'hDEAD);
    applyStimulus(1'b1, AW'(32'h04), DW'(32'hA5));
    checkOutput("wr_psel_not_yet", PSELx, 0);
    waitCycle();
    checkOutput("wr_setup_psel", PSELx, 1);
    checkOutput("wr_setup_penable", PENABLE, 0);
    checkOutput("wr_setup_paddr", PADDR, 32'h04);
    checkOutput("wr_setup_pwrite", PWRITE, 1);
    checkOutput("wr_setup_pwdata", PWDATA, 32'hA5);
    waitCycle();
    checkOutput("wr_access_psel", PSELx, 1);
    checkOutput("wr_access_penable", PENABLE, 1);
    checkOutput("wr_access_pwdata", PWDATA, 32'hA5);
    checkOutput("wr_access_rsp_valid", rsp_valid, 0);
    waitCycle();
    checkOutput("wr_rsp_valid", rsp_valid, 1);
    checkOutput("wr_rsp_psel", PSELx, 0);
    checkOutput("wr_rsp_error", rsp_error, 0);
    checkOutput("wr_rsp_rdata", rsp_rdata, 0);
    waitCycle();
    checkOutput("wr_rsp_held", rsp_valid, 1);
    rsp_ready = 1'b1;
    waitCycle();
    rsp_ready = 1'b0;
    checkOutput("wr_idle_rsp_valid", rsp_valid, 0);
    checkOutput("wr_idle_psel", PSELx, 0);
    checkOutput("wr_idle_paddr_kept", PADDR, 32'h04);

    // Read from 0x08 with three wait states
    PREADY     = 1'b0;
    prdata_val = DW'(32'h5A);
    applyStimulus(1'b0, AW'(32'h08), '0);
    waitCycle();
    checkOutput("rd_setup_pwrite", PWRITE, 0);
    checkOutput("rd_setup_paddr", PADDR, 32'h08);
    waitCycle();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rd_access%0d_penable", i), PENABLE, 1);
      if (i == 3) PREADY = 1'b1;
      waitCycle();
    end
    checkOutput("rd_rsp_valid", rsp_valid, 1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'h5A);
    checkOutput("rd_rsp_error", rsp_error, 0);
    checkOutput("rd_rsp_psel", PSELx, 0);
    rsp_ready = 1'b1;
    waitCycle();
    rsp_ready = 1'b0;

    // Slave error on a read
    PREADY     = 1'b1;
    PSLVERR    = 1'b1;
    prdata_val = DW'(32'hFF);
    applyStimulus(1'b0, AW'(32'h0C), '0);
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("err_rsp_valid", rsp_valid, 1);
    checkOutput("err_rsp_error", rsp_error, 1);
    checkOutput("err_rsp_timeout", rsp_timeout, 0);
    checkOutput("err_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    waitCycle();
    rsp_ready = 1'b0;
    PSLVERR   = 1'b0;

    // FIFO full: first command sits in ACCESS, next four fill the buffer
    PREADY         = 1'b0;
    use_addr_model = 1'b1;
    rsp_ready      = 1'b1;
    for (int i = 0; i < 6; i++) exp_rdata[i] = DW'(32'h10 + 4 * i) ^ DW'(32'h3C);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, AW'(32'h10 + 4 * i), '0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = AW'(32'h24);
    checkOutput("full_cmd_ready", cmd_ready, 0);
    checkOutput("full_first_in_access", PENABLE, 1);
    waitCycle();
    waitCycle();
    checkOutput("full_cmd_ready_held", cmd_ready, 0);
    PREADY   = 1'b1;
    rsp_idx  = 0;
    accepted = 1'b0;
    for (int cyc = 0; cyc < 100 && rsp_idx < 6; cyc++) begin
      take_cmd = cmd_valid && cmd_ready;
      if (take_cmd) checkOutput("cmd6_after_pop", (rsp_idx >= 1), 1);
      if (rsp_valid) begin
        checkOutput($sformatf("fifo_rsp%0d_rdata", rsp_idx), rsp_rdata, exp_rdata[rsp_idx]);
        rsp_idx++;
      end
      waitCycle();
      if (take_cmd) begin
        cmd_valid = 1'b0;
        accepted  = 1'b1;
      end
    end
    checkOutput("fifo_rsp_count", rsp_idx, 6);
    checkOutput("fifo_cmd6_accepted", accepted, 1);
    rsp_ready      = 1'b0;
    use_addr_model = 1'b0;
    cmd_valid      = 1'b0;
    waitCycle();

    // Timeout: PREADY never asserts
    PREADY = 1'b0;
    applyStimulus(1'b1, AW'(32'h20), DW'(32'h77));
    waitCycle();
    checkOutput("to_setup_psel", PSELx, 1);
    waitCycle();
    cnt = 0;
    while (PENABLE && cnt < 20) begin
      cnt++;
      waitCycle();
    end
    checkOutput("to_access_cycles", cnt, 8);
    checkOutput("to_psel_dropped", PSELx, 0);
    checkOutput("to_rsp_valid", rsp_valid, 1);
    checkOutput("to_rsp_error", rsp_error, 1);
    checkOutput("to_rsp_timeout", rsp_timeout, 1);
    checkOutput("to_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    waitCycle();
    rsp_ready = 1'b0;
    checkOutput("to_rsp_cleared", rsp_valid, 0);

    // Reset in the middle of ACCESS with another command queued
    PREADY = 1'b0;
    applyStimulus(1'b0, AW'(32'h30), '0);
    applyStimulus(1'b1, AW'(32'h34), DW'(32'h99));
    waitCycle();
    checkOutput("rstmid_in_access", PENABLE, 1);
    PRESET = 1'b1;
    #1;
    checkOutput("rstmid_psel", PSELx, 0);
    checkOutput("rstmid_penable", PENABLE, 0);
    checkOutput("rstmid_rsp_valid", rsp_valid, 0);
    checkOutput("rstmid_cmd_ready", cmd_ready, 1);
    checkOutput("rstmid_paddr", PADDR, 0);
    waitCycle();
    waitCycle();
    PRESET    = 1'b0;
    PREADY    = 1'b1;
    rsp_ready = 1'b1;
    any_bad   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      any_bad = any_bad | rsp_valid | PSELx;
      waitCycle();
    end
    checkOutput("rstmid_no_stale", any_bad, 0);
    checkOutput("rstmid_post_ready", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
